// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment result display controller.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } disp_state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_display.sv
// Hex digit to active-low 7-segment decoder (bit 6 = segment a, bit 0 = segment g).
// Code 4'hF is reserved as the blank code and lights nothing.
module hex_display (
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'b1111111;
        case (digit)
            4'h0: seg_n = 7'b0000001;
            4'h1: seg_n = 7'b1001111;
            4'h2: seg_n = 7'b0010010;
            4'h3: seg_n = 7'b0000110;
            4'h4: seg_n = 7'b1001100;
            4'h5: seg_n = 7'b0100100;
            4'h6: seg_n = 7'b0100000;
            4'h7: seg_n = 7'b0001111;
            4'h8: seg_n = 7'b0000000;
            4'h9: seg_n = 7'b0000100;
            4'hA: seg_n = 7'b0001000;
            4'hB: seg_n = 7'b1100000;
            4'hC: seg_n = 7'b0110001;
            4'hD: seg_n = 7'b1000010;
            4'hE: seg_n = 7'b0110000;
            default: seg_n = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/result_display_ctrl.sv
// Accepts a binary result, converts it to BCD one bit per cycle (double-dabble),
// then commits blanked/overflow-checked digit codes to the 7-segment decoders.
module result_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [VALUE_W-1:0]      in_value,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7*NUM_DIGITS-1:0] seg_n,
    output logic                    overflow,
    output logic                    done
);

    import disp_pkg::*;

    localparam int     BCD_W       = 4 * NUM_DIGITS;
    localparam int     CNT_W       = $clog2(VALUE_W + 1);
    localparam longint MAX_FULL    = pow10(NUM_DIGITS) - 1;
    localparam longint VALUE_LIMIT = (longint'(1) << VALUE_W) - 1;
    // Saturate when every VALUE_W-bit value fits on the display.
    localparam logic [VALUE_W-1:0] MAX_VAL =
        (MAX_FULL > VALUE_LIMIT) ? {VALUE_W{1'b1}} : VALUE_W'(MAX_FULL);

    disp_state_t        state_q, state_d;
    logic [VALUE_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               overflow_q, overflow_d;
    logic [BCD_W-1:0]   digits_q, digits_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   commit_codes;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Scan from the top digit down; a digit is blanked until a nonzero one is seen.
    always_comb begin
        logic seen_nz;
        logic [3:0] nib;
        seen_nz      = 1'b0;
        nib          = 4'h0;
        commit_codes = {NUM_DIGITS{BLANK_CODE}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
            if (nib != 4'h0) begin
                seen_nz = 1'b1;
            end
            if (ovf_pend_q) begin
                commit_codes[4*i +: 4] = BLANK_CODE;
            end else if ((LZ_BLANK != 0) && !seen_nz && (i != 0)) begin
                commit_codes[4*i +: 4] = BLANK_CODE;
            end else begin
                commit_codes[4*i +: 4] = nib;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        digits_d   = digits_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d    = in_value;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(VALUE_W);
                    ovf_pend_d = (in_value > MAX_VAL);
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d            = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d   = commit_codes;
                overflow_d = ovf_pend_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign done     = (state_q == COMMIT);
    assign overflow = overflow_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex_display u_hex (
            .digit (digits_q[4*g +: 4]),
            .seg_n (seg_n[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_result_display_ctrl.sv
// Directed bench for result_display_ctrl: latency, blanking, overflow,
// back-to-back handshake and mid-conversion reset.
module tb_result_display_ctrl;

    localparam logic [6:0] D0 = 7'b0000001;
    localparam logic [6:0] D1 = 7'b1001111;
    localparam logic [6:0] D2 = 7'b0010010;
    localparam logic [6:0] D3 = 7'b0000110;
    localparam logic [6:0] D4 = 7'b1001100;
    localparam logic [6:0] D5 = 7'b0100100;
    localparam logic [6:0] D6 = 7'b0100000;
    localparam logic [6:0] D7 = 7'b0001111;
    localparam logic [6:0] D9 = 7'b0000100;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic [13:0] in_value;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [27:0] seg_n, seg_n2;
    logic        overflow, overflow2;
    logic        done, done2;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [31:0] expShown;
    logic        expOvfShown;

    result_display_ctrl #(.NUM_DIGITS(4), .VALUE_W(14), .LZ_BLANK(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .seg_n    (seg_n),
        .overflow (overflow),
        .done     (done)
    );

    result_display_ctrl #(.NUM_DIGITS(4), .VALUE_W(14), .LZ_BLANK(0)) dut_nb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready2),
        .seg_n    (seg_n2),
        .overflow (overflow2),
        .done     (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] segs(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {4'b0000, d3, d2, d1, d0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Presents a value and returns on the first falling edge after the accept edge.
    task automatic applyStimulus(input logic [13:0] value, input bit hold);
        int bound;
        @(negedge clk);
        in_value = value;
        in_valid = 1'b1;
        bound    = 0;
        while (!in_ready && bound < 40) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 40) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Waits for done and checks latency, hold during COMMIT, then the committed result.
    task automatic finishValue(input string tag, input logic [31:0] expSeg, input logic expOvf);
        int n;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'd15);
        checkOutput({tag, "_hold_seg"}, {4'b0000, seg_n}, expShown);
        checkOutput({tag, "_hold_ovf"}, 32'(overflow), 32'(expOvfShown));
        checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_seg"}, {4'b0000, seg_n}, expSeg);
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'(expOvf));
        checkOutput({tag, "_done_low"}, 32'(done), 32'd0);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
        expShown    = expSeg;
        expOvfShown = expOvf;
    endtask

    task automatic runValue(input string tag, input logic [13:0] value,
                            input logic [31:0] expSeg, input logic expOvf);
        applyStimulus(value, 1'b0);
        finishValue(tag, expSeg, expOvf);
    endtask

    initial begin
        int k;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_value = '0;

        #12;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_seg", {4'b0000, seg_n}, segs(BL, BL, BL, BL));
        checkOutput("reset_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        checkOutput("reset_seg_nb", {4'b0000, seg_n2}, segs(BL, BL, BL, BL));
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        expShown    = segs(BL, BL, BL, BL);
        expOvfShown = 1'b0;

        runValue("v1234", 14'd1234, segs(D1, D2, D3, D4), 1'b0);
        runValue("v7", 14'd7, segs(BL, BL, BL, D7), 1'b0);
        checkOutput("v7_nb_seg", {4'b0000, seg_n2}, segs(D0, D0, D0, D7));
        runValue("v0", 14'd0, segs(BL, BL, BL, D0), 1'b0);
        checkOutput("v0_nb_seg", {4'b0000, seg_n2}, segs(D0, D0, D0, D0));
        runValue("v12000", 14'd12000, segs(BL, BL, BL, BL), 1'b1);
        checkOutput("v12000_nb_ovf", 32'(overflow2), 32'd1);
        runValue("v9999", 14'd9999, segs(D9, D9, D9, D9), 1'b0);

        // Back-to-back with in_valid held; in_value wiggles while busy.
        applyStimulus(14'd42, 1'b1);
        k = 1;
        while (!in_ready && k < 40) begin
            if (k == 3) in_value = 14'd999;
            if (k == 10) in_value = 14'd56;
            if (k == 15) checkOutput("b2b_done", 32'(done), 32'd1);
            @(negedge clk);
            k++;
        end
        checkOutput("b2b_gap", 32'(k), 32'd16);
        checkOutput("b2b_seg42", {4'b0000, seg_n}, segs(BL, BL, D4, D2));
        expShown = segs(BL, BL, D4, D2);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        finishValue("b2b56", segs(BL, BL, D5, D6), 1'b0);

        // Reset in the middle of a conversion.
        applyStimulus(14'd1234, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_seg", {4'b0000, seg_n}, segs(BL, BL, BL, BL));
        checkOutput("midrst_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready_after", 32'(in_ready), 32'd1);
        checkOutput("midrst_seg_after", {4'b0000, seg_n}, segs(BL, BL, BL, BL));
        expShown    = segs(BL, BL, BL, BL);
        expOvfShown = 1'b0;
        runValue("v321", 14'd321, segs(BL, D3, D2, D1), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/result_display_ctrl.md
Name: result_display_ctrl

Overview:
- Sequential display controller for the board's 7-segment bank.
- Accepts a binary result word (e.g. a class index or score from the accelerator) over a valid/ready handshake.
- Converts the word to BCD iteratively (double-dabble, one bit per cycle), applies leading-zero blanking and overflow detection, then commits per-digit codes to registered outputs.
- Those outputs drive one hex_display decoder per digit.

Parameters:
- NUM_DIGITS, 4: number of 7-segment digits driven.
- VALUE_W, 14: width of the input binary value.
- LZ_BLANK, 1: 1 = blank leading zeros; 0 = show all zeros.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_value  in  VALUE_W  unsigned binary value to display.
- in_valid  in  1  in_value is valid.
- in_ready  out  1  controller can accept a value.
- seg_n  out  7*NUM_DIGITS  active-low segments a-g. Digit i is at [7*i +: 7]; i=0 is the least significant digit.
- overflow  out  1  last committed value exceeded 10^NUM_DIGITS-1.
- done  out  1  one-cycle pulse when new digits are committed.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low: rst_n low forces all registers immediately, with no dependence on clk.
- Reset values: state=IDLE, in_ready=1, done=0, overflow=0. Every digit code register = 4'hF (blank), so seg_n is all 1s.
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: in_ready=1. On in_valid && in_ready:
    - latch in_value into the shift register;
    - clear the BCD accumulator (4*NUM_DIGITS bits);
    - load iteration counter = VALUE_W;
    - latch ovf_pend = (in_value > MAX_VAL), where MAX_VAL = 10^NUM_DIGITS-1, truncated/saturated to VALUE_W bits;
    - go to CONVERT.
    - Without a handshake, stay in IDLE and hold all outputs.
  - CONVERT: in_ready=0. Each cycle:
    - add 3 to every BCD nibble >= 5;
    - shift {bcd, shift_reg} left by 1;
    - decrement the counter.
    - Go to COMMIT on the cycle the counter reaches 0, i.e. exactly VALUE_W cycles in CONVERT.
  - COMMIT: in_ready=0, done=1 for this cycle only. On the clock edge ending COMMIT:
    - digit registers load from the BCD result, with blanking applied;
    - overflow loads ovf_pend;
    - return to IDLE.
- Latency and throughput:
  - Handshake at edge T; new seg_n and overflow are visible after edge T+VALUE_W+1.
  - in_ready is low for exactly VALUE_W+1 cycles, so minimum spacing between accepts is VALUE_W+2 cycles.
  - Latency is fixed and does not depend on the value or on overflow.
- Blanking:
  - Code 4'hF means blank; the decoder outputs 7'b1111111 for it.
  - With LZ_BLANK=1, every digit above the most significant nonzero digit is blanked.
  - Digit 0 is never blanked for a non-overflow value, so value 0 shows a single "0".
- Overflow: when ovf_pend=1, all digits commit as 4'hF and overflow=1. The next non-overflow commit clears overflow.
- Handshake rules:
  - in_value is sampled only on the accept edge.
  - Changes to in_value or in_valid while in_ready=0 are ignored; held in_valid is accepted on the first IDLE cycle.
- Hold behaviour: displayed digits hold their previous value throughout CONVERT and COMMIT. There is no intermediate flicker.
- Reset mid-operation: the conversion is abandoned, the display returns to blank, and in_ready=1 from the first cycle after rst_n deasserts.

Decomposition:
- Shared package disp_pkg:
  - typedef disp_state_t {IDLE, CONVERT, COMMIT};
  - localparam BLANK_CODE = 4'hF;
  - constant function pow10(n) used to derive MAX_VAL.
- Sub-module: the existing hex_display decoder, instantiated NUM_DIGITS times in a generate loop on the registered digit codes. All sequencing stays in result_display_ctrl.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> seg_n all 1s immediately, in_ready=1, done=0, overflow=0.
- Accept 1234 -> done pulses 15 cycles after the accept edge. Per digit, digit3..0:
  - digit3 = 1001111 ("1");
  - digit2 = 0010010 ("2");
  - digit1 = 0000110 ("3");
  - digit0 = 1001100 ("4").
  - overflow=0.
- Blanking with LZ_BLANK=1:
  - value 7 -> digits 3..1 = 1111111, digit0 = 0001111;
  - value 0 -> digit0 = 0000001, rest blank;
  - rerun with LZ_BLANK=0 and value 7 -> digits 3..1 = 0000001.
- Overflow: accept 12000 -> all digits 1111111, overflow=1; then accept 9999 -> all digits 0000100, overflow=0.
- Back-to-back: hold in_valid with 42, then 56 -> second accept occurs exactly 16 cycles after the first. In_value changes during CONVERT have no effect; the display shows 42, then 56.
- Reset mid-CONVERT, after 5 cycles -> display blank, in_ready=1 after release; a fresh accept of 321 completes normally.
